// File: rtl/tt_vfp_widen_sequencer.sv
// Operand-staging sequencer in front of the vector FP recode encoder: holds one source chunk
// and issues it as one beat (same-width) or two beats (widen lo/hi). Optional perf counters: TT_VFP_WIDEN_SEQ_PERF_EN.
module tt_vfp_widen_sequencer #(
    parameter int NUM_LANE = 2,
    parameter int TAG_W    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_flush,
    input  logic                    i_src_valid,
    output logic                    o_src_ready,
    input  logic [NUM_LANE*64-1:0]  i_src_data,
    input  logic                    i_src_widen,
    input  logic [TAG_W-1:0]        i_src_tag,
    input  logic                    i_src_last,
    output logic                    o_enc_valid,
    input  logic                    i_enc_ready,
    output logic [NUM_LANE*64-1:0]  o_enc_data,
    output logic [1:0]              o_enc_sel,
    output logic                    o_enc_half,
    output logic [TAG_W-1:0]        o_enc_tag,
    output logic                    o_enc_last,
    output logic                    o_busy
`ifdef TT_VFP_WIDEN_SEQ_PERF_EN
    ,
    output logic [31:0]             o_perf_beats,
    output logic [31:0]             o_perf_stall
`endif
);

    localparam logic [1:0] SEL_SAME = 2'd0;
    localparam logic [1:0] SEL_LO   = 2'd2;
    localparam logic [1:0] SEL_HI   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAME = 2'd1,
        LO   = 2'd2,
        HI   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_LANE*64-1:0]   data_q, data_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic                     heldLast_q, heldLast_d;
    logic                     valid_q, valid_d;
    logic [1:0]               sel_q, sel_d;
    logic                     half_q, half_d;
    logic                     last_q, last_d;
    logic                     srcReady;
    logic                     accept;

    // A new chunk may load when nothing is held, or when the final beat retires this cycle.
    assign srcReady = !i_reset && !i_flush &&
                      ((state_q == IDLE) ||
                       (((state_q == SAME) || (state_q == HI)) && i_enc_ready));
    assign accept   = i_src_valid && srcReady;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tag_d      = tag_q;
        heldLast_d = heldLast_q;
        valid_d    = valid_q;
        sel_d      = sel_q;
        half_d     = half_q;
        last_d     = last_q;

        if (i_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sel_d   = SEL_SAME;
            half_d  = 1'b0;
            last_d  = 1'b0;
        end else if (accept) begin
            data_d     = i_src_data;
            tag_d      = i_src_tag;
            heldLast_d = i_src_last;
            valid_d    = 1'b1;
            half_d     = 1'b0;
            if (i_src_widen) begin
                state_d = LO;
                sel_d   = SEL_LO;
                last_d  = 1'b0;
            end else begin
                state_d = SAME;
                sel_d   = SEL_SAME;
                last_d  = i_src_last;
            end
        end else begin
            unique case (state_q)
                LO: begin
                    if (i_enc_ready) begin
                        state_d = HI;
                        sel_d   = SEL_HI;
                        half_d  = 1'b1;
                        last_d  = heldLast_q;
                    end
                end
                SAME, HI: begin
                    if (i_enc_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        sel_d   = SEL_SAME;
                        half_d  = 1'b0;
                        last_d  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            tag_q      <= '0;
            heldLast_q <= 1'b0;
            valid_q    <= 1'b0;
            sel_q      <= SEL_SAME;
            half_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            heldLast_q <= heldLast_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            half_q     <= half_d;
            last_q     <= last_d;
        end
    end

    assign o_src_ready = srcReady;
    assign o_enc_valid = valid_q;
    assign o_enc_data  = data_q;
    assign o_enc_sel   = sel_q;
    assign o_enc_half  = half_q;
    assign o_enc_tag   = tag_q;
    assign o_enc_last  = last_q;
    assign o_busy      = valid_q || (state_q != IDLE);

`ifdef TT_VFP_WIDEN_SEQ_PERF_EN
    logic [31:0] perfBeats_q;
    logic [31:0] perfStall_q;

    // Saturating counters; flush intentionally leaves them alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perfBeats_q <= '0;
            perfStall_q <= '0;
        end else begin
            if (valid_q && i_enc_ready && (perfBeats_q != 32'hFFFF_FFFF)) begin
                perfBeats_q <= perfBeats_q + 32'd1;
            end
            if (valid_q && !i_enc_ready && (perfStall_q != 32'hFFFF_FFFF)) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign o_perf_beats = perfBeats_q;
    assign o_perf_stall = perfStall_q;
`endif

endmodule

// File: doc/tt_vfp_widen_sequencer.md
Name: tt_vfp_widen_sequencer

Overview:
- Operand-staging stage directly upstream of the vector FP recode encoder.
- Accepts one source chunk (NUM_LANE x 64 bits) per valid/ready handshake and drives the encoder's data and select inputs.
- Non-widening ops: one beat, select = 0 (same).
- Widening ops: the chunk is held and issued twice, first select = 2 (upscale_lo), then select = 3 (upscale_hi). Each beat is tagged so the downstream FP pipe can reassemble results.

Parameters:
- NUM_LANE, 2, number of 64-bit lanes per chunk; must match the encoder.
- TAG_W, 8, width of the opaque instruction/uop tag carried with each chunk.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous squash of held and pending work.
- i_src_valid  input  1  source chunk valid.
- o_src_ready  output  1  sequencer can accept a chunk this cycle.
- i_src_data  input  NUM_LANE*64  source chunk; lane i occupies bits [64i+63:64i].
- i_src_widen  input  1  1 = widening op (two beats), 0 = same-width (one beat).
- i_src_tag  input  TAG_W  uop tag.
- i_src_last  input  1  last chunk of the vector instruction.
- o_enc_valid  output  1  beat valid toward encoder/FP pipe.
- i_enc_ready  input  1  downstream accepts beat.
- o_enc_data  output  NUM_LANE*64  held chunk, unmodified.
- o_enc_sel  output  2  encoder data_sel: 0 same, 2 upscale_lo, 3 upscale_hi; never 1.
- o_enc_half  output  1  0 = lo/same beat, 1 = hi beat.
- o_enc_tag  output  TAG_W  tag of held chunk.
- o_enc_last  output  1  set only on the final beat of a chunk whose i_src_last was 1.
- o_busy  output  1  o_enc_valid, or a chunk is held.

Behaviour:
- Single clock i_clk; reset is synchronous and active-high (i_reset); all state updates on the rising edge.
- Reset values:
  - o_enc_valid = 0, o_enc_sel = 0, o_enc_half = 0, o_enc_last = 0, o_busy = 0.
  - o_enc_data = 0, o_enc_tag = 0.
  - Internal state = IDLE.
  - o_src_ready = 1 from the first cycle after reset deasserts.
- All o_enc_* outputs are registered. Latency from input handshake to o_enc_valid is 1 cycle.
- FSM states:
  - IDLE: nothing held.
  - SAME: single beat pending.
  - LO: widen lo beat pending.
  - HI: widen hi beat pending.
- o_src_ready = (state == IDLE) or (state in {SAME, HI} and i_enc_ready). This gives full-throughput back-to-back issue; the register is reloaded the same cycle its final beat retires.
- o_src_ready has no combinational dependence on i_src_valid.
- Transitions:
  - On an input handshake the next state is LO if i_src_widen = 1, else SAME. Data, tag and last are captured.
  - LO with i_enc_ready -> HI. o_enc_sel switches 2 -> 3 and o_enc_half becomes 1; data and tag are unchanged.
  - SAME or HI with i_enc_ready and no new handshake -> IDLE, o_enc_valid = 0.
  - No handshake in LO, SAME or HI: all outputs hold stable (AXI-style; valid never drops without ready).
- o_enc_last = held_last and (state in {SAME, HI}). The LO beat never carries last.
- i_flush:
  - Highest priority below reset. Next state = IDLE, o_enc_valid = 0.
  - o_src_ready = 0 in the flush cycle; any coincident input handshake is dropped.
  - Flush in HI or LO discards the remaining beat(s).
- Reset mid-operation: identical to flush, plus output data and tag cleared to 0.
- A simultaneous downstream retire and upstream accept in SAME/HI loads the new chunk; no bubble.

Optional Feature:
- Macro: TT_VFP_WIDEN_SEQ_PERF_EN.
- When defined, two output ports are added, both cleared by i_reset and not by i_flush:
  - o_perf_beats (32 bits): counts retired beats (o_enc_valid and i_enc_ready).
  - o_perf_stall (32 bits): counts cycles with o_enc_valid = 1 and i_enc_ready = 0.
- Both counters saturate at 0xFFFFFFFF.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Same-width chunk, i_enc_ready held 1: data 0x1111_2222_3333_4444_5555_6666_7777_8888, tag 0x05, last 1 -> next cycle o_enc_valid = 1, sel = 0, half = 0, last = 1 for exactly 1 cycle; o_src_ready stays 1.
- Widen chunk, tag 0x2A, last 1, ready held 1 -> beat 1: sel = 2, half = 0, last = 0; beat 2: sel = 3, half = 1, last = 1, same data; o_src_ready = 0 during the LO beat.
- Three back-to-back widen chunks, ready held 1 -> 6 consecutive valid beats, sel pattern 2, 3, 2, 3, 2, 3, no bubbles.
- Backpressure: i_enc_ready = 0 for 4 cycles during the HI beat -> outputs stable for 4 cycles; retire on the 5th cycle; with perf enabled, o_perf_stall = 4.
- Flush during the HI beat while i_src_valid = 1 -> next cycle o_enc_valid = 0, state IDLE, incoming chunk not captured; o_src_ready = 1 one cycle later.
- Reset asserted while in LO -> next cycle all outputs are at reset values; a subsequent same-width chunk issues normally with sel = 0.
